// File: rtl/spi_sram_bridge.sv
// Byte-stream front end for the SPI side of the SRAM arbiter: byte address
// auto-increment, write FIFO, read word buffer. Optional SPI_SRAM_PREFETCH_EN.
//
// state   | meaning
// SYNC    | align spi_req to spi_ack after reset
// IDLE    | no request outstanding; issue write/read when needed
// WR_WAIT | write outstanding, waiting for ack match
// RD_WAIT | read outstanding, waiting for ack match
// RD_DATA | counting READ_LAT edges before sampling the read word
module spi_sram_bridge #(
    parameter int WR_FIFO_DEPTH = 4,
    parameter int READ_LAT      = 4
) (
    input  logic        clk200,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic        cmd_read,
    input  logic [19:0] cmd_address,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_full,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_req,
    output logic        busy,
    output logic        spi_req,
    input  logic        spi_ack,
    output logic        spi_read,
    output logic [18:0] spi_address,
    output logic        spi_ub,
    output logic [7:0]  spi_out_sram_in,
    input  logic [15:0] spi_in_sram_out
);
    localparam int AW = $clog2(WR_FIFO_DEPTH);
    localparam int LW = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {SYNC, IDLE, WR_WAIT, RD_WAIT, RD_DATA} state_t;
    state_t state, state_nx;

    logic [27:0]   fifo_mem [WR_FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic [AW:0]   fifo_cnt;
    logic [27:0]   fifo_head;
    logic          fifo_empty, push, pop, consume, pf_hit, ack_match;
    logic [19:0]   ptr;
    logic          mode_rd;
    logic          buf_vld;
    logic [18:0]   buf_tag;
    logic [15:0]   buf_word;
    logic          gen, req_gen;
    logic [LW-1:0] lat_cnt;
    logic          issue_wr, issue_rd, issue_ub, lat_load, sample;
    logic [18:0]   issue_word;

    assign fifo_empty = (fifo_cnt == '0);
    assign wr_full    = (fifo_cnt == (AW+1)'(WR_FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_idx];
    assign push       = wr_valid & ~mode_rd & ~wr_full;
    assign ack_match  = (spi_ack == spi_req);
    assign rd_valid   = buf_vld & (buf_tag == ptr[19:1]);
    assign rd_data    = ptr[0] ? buf_word[7:0] : buf_word[15:8];
    assign consume    = rd_req & rd_valid;
    assign busy       = ~fifo_empty | (state == WR_WAIT) | (state == RD_WAIT) | (state == RD_DATA);

`ifdef SPI_SRAM_PREFETCH_EN
    assign pf_hit = mode_rd & consume & ptr[0] & ~cmd_start;
`else
    assign pf_hit = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        issue_word = ptr[19:1];
        issue_ub   = ~ptr[0];
        pop        = 1'b0;
        lat_load   = 1'b0;
        sample     = 1'b0;
        case (state)
            SYNC: state_nx = IDLE;
            IDLE: begin
                if (!fifo_empty) begin
                    issue_wr = 1'b1;
                    state_nx = WR_WAIT;
                end else if (pf_hit) begin
                    issue_rd   = 1'b1;
                    issue_word = ptr[19:1] + 19'd1;
                    issue_ub   = 1'b1;
                    state_nx   = RD_WAIT;
                end else if (mode_rd && !rd_valid) begin
                    issue_rd = 1'b1;
                    state_nx = RD_WAIT;
                end
            end
            WR_WAIT: if (ack_match) begin
                pop      = 1'b1;
                state_nx = IDLE;
            end
            RD_WAIT: if (ack_match) begin
                lat_load = 1'b1;
                state_nx = RD_DATA;
            end
            RD_DATA: if (lat_cnt == '0) begin
                sample   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) state <= SYNC;
        else          state <= state_nx;
    end

    always_ff @(posedge clk200) begin
        if (push) fifo_mem[wr_idx] <= {ptr, wr_data};
    end

    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            spi_req         <= 1'b0;
            spi_read        <= 1'b1;
            spi_address     <= '0;
            spi_ub          <= 1'b0;
            spi_out_sram_in <= '0;
            wr_idx          <= '0;
            rd_idx          <= '0;
            fifo_cnt        <= '0;
            ptr             <= '0;
            mode_rd         <= 1'b0;
            buf_vld         <= 1'b0;
            buf_tag         <= '0;
            buf_word        <= '0;
            gen             <= 1'b0;
            req_gen         <= 1'b0;
            lat_cnt         <= '0;
        end else begin
            if (state == SYNC) spi_req <= spi_ack;
            if (issue_wr) begin
                spi_read        <= 1'b0;
                spi_address     <= fifo_head[27:9];
                spi_ub          <= ~fifo_head[8];
                spi_out_sram_in <= fifo_head[7:0];
                spi_req         <= ~spi_req;
            end
            if (issue_rd) begin
                spi_read    <= 1'b1;
                spi_address <= issue_word;
                spi_ub      <= issue_ub;
                spi_req     <= ~spi_req;
                req_gen     <= gen;
            end
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            if (lat_load)
                lat_cnt <= LW'(READ_LAT - 1);
            else if (state == RD_DATA && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            // Data from a request issued before the latest cmd_start is stale.
            if (sample && req_gen == gen) begin
                buf_vld  <= 1'b1;
                buf_tag  <= spi_address;
                buf_word <= spi_in_sram_out;
            end
            if (push || consume) ptr <= ptr + 20'd1;
            if (cmd_start) begin
                ptr     <= cmd_address;
                mode_rd <= cmd_read;
                buf_vld <= 1'b0;
                gen     <= ~gen;
            end
        end
    end
endmodule
